// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader_pkg
// Description : Shared types and constants for the UART boot loader.
//               loader_state_t : frame parser states
//               C_SYNC_BYTE    : default frame header byte
// Revision    : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CNT_LO  = 3'd1,
        CNT_HI  = 3'd2,
        ADDR_LO = 3'd3,
        ADDR_HI = 3'd4,
        DATA    = 3'd5,
        CSUM    = 3'd6
    } loader_state_t;

    localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_packer
// Description : Collects four bytes little-endian (first byte -> [7:0]) and
//               presents the finished word with a one-cycle valid pulse the
//               cycle after the fourth byte is accepted.
// Ports       : clk, rst            clock, async active-high reset
//               i_clr               return byte index to 0 (partial word dropped)
//               i_byte_dv, i_byte   byte strobe and data
//               o_last_byte         comb: current strobe completes a word
//               o_word_valid        registered 1-cycle word strobe
//               o_word              assembled word, held until the next one
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_dv,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;

    assign o_last_byte  = i_byte_dv && !i_clr && (r_idx == 2'd3);
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= 2'd0;
            r_shift      <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clr) begin
                r_idx <= 2'd0;
            end else if (i_byte_dv) begin
                if (r_idx == 2'd3) begin
                    r_word       <= {i_byte, r_shift};
                    r_word_valid <= 1'b1;
                    r_idx        <= 2'd0;
                end else begin
                    r_shift[r_idx*8 +: 8] <= i_byte;
                    r_idx                 <= r_idx + 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader
// Description : Parses boot-load frames from a UART byte stream
//               (SYNC, CNT_LO, CNT_HI, ADDR_LO, ADDR_HI, CNT*4 data, CSUM)
//               and writes 32-bit words into CPU memory while holding the
//               CPU in reset.
// Ports       : clk, rst              clock, async active-high reset
//               i_rx_data, i_rx_dv    received byte and 1-cycle strobe
//               o_mem_we/addr/wdata   memory write port (1-cycle strobe)
//               o_cpu_rst, o_busy     high while a frame is in flight
//               o_done, o_err         1-cycle result pulses
// Revision    : 1.0 - initial release
// ============================================================================
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_W       = 16,
    parameter int         TIMEOUT_CLKS = 43400,
    parameter logic [7:0] SYNC_BYTE    = C_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_dv,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int c_TMO_W = $clog2(TIMEOUT_CLKS + 1);

    loader_state_t     r_state, w_state_nxt;
    logic [15:0]       r_cnt;        // words still to be written
    logic [7:0]        r_addr_lo;
    logic [ADDR_W-1:0] r_word_addr;  // address of the word being assembled
    logic [7:0]        r_sum;
    logic [c_TMO_W-1:0] r_tmo;
    logic              r_busy, r_done, r_err;
    logic              w_timeout, w_last_byte;

    // Assembler is held clear outside DATA so every frame starts on byte 0.
    uart_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (r_state != DATA),
        .i_byte_dv    (i_rx_dv && (r_state == DATA)),
        .i_byte       (i_rx_data),
        .o_last_byte  (w_last_byte),
        .o_word_valid (o_mem_we),
        .o_word       (o_mem_wdata)
    );

    // The counter would reach TIMEOUT_CLKS on this edge.
    assign w_timeout = (r_state != IDLE) && !i_rx_dv &&
                       (r_tmo == c_TMO_W'(TIMEOUT_CLKS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_rx_dv && i_rx_data == SYNC_BYTE) w_state_nxt = CNT_LO;
            CNT_LO:  if (i_rx_dv) w_state_nxt = CNT_HI;
            CNT_HI:  if (i_rx_dv) w_state_nxt = ADDR_LO;
            ADDR_LO: if (i_rx_dv) w_state_nxt = ADDR_HI;
            ADDR_HI: if (i_rx_dv) w_state_nxt = (r_cnt == 16'd0) ? CSUM : DATA;
            DATA:    if (w_last_byte && r_cnt == 16'd1) w_state_nxt = CSUM;
            CSUM:    if (i_rx_dv) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_timeout) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 16'd0;
            r_addr_lo   <= 8'd0;
            r_word_addr <= '0;
            r_sum       <= 8'd0;
            r_tmo       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= 1'b0;
            r_err   <= w_timeout;

            if (r_state == IDLE || i_rx_dv) r_tmo <= '0;
            else                            r_tmo <= r_tmo + c_TMO_W'(1);

            // Word address advances as each write is presented.
            if (o_mem_we) r_word_addr <= r_word_addr + ADDR_W'(1);

            if (i_rx_dv) begin
                case (r_state)
                    IDLE:    r_sum <= 8'd0;
                    CNT_LO:  begin r_cnt[7:0]  <= i_rx_data; r_sum <= r_sum + i_rx_data; end
                    CNT_HI:  begin r_cnt[15:8] <= i_rx_data; r_sum <= r_sum + i_rx_data; end
                    ADDR_LO: begin r_addr_lo   <= i_rx_data; r_sum <= r_sum + i_rx_data; end
                    ADDR_HI: begin
                        r_word_addr <= ADDR_W'({i_rx_data, r_addr_lo});
                        r_sum       <= r_sum + i_rx_data;
                    end
                    DATA: begin
                        r_sum <= r_sum + i_rx_data;
                        if (w_last_byte) r_cnt <= r_cnt - 16'd1;
                    end
                    CSUM: begin
                        r_done <= (i_rx_data == r_sum);
                        r_err  <= (i_rx_data != r_sum);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_mem_addr = r_word_addr;
    assign o_busy     = r_busy;
    assign o_cpu_rst  = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_loader
// Description : Self-checking bench for uart_loader. A frame-level reference
//               model predicts the writes and the result pulse of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

    localparam int ADDR_W = 16;
    localparam int TMO    = 300;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_dv;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst, busy, done, err;

    always #5 clk = ~clk;

    uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_dv(rx_dv),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_cpu_rst(cpu_rst), .o_busy(busy), .o_done(done), .o_err(err)
    );

    int vectors = 0, miscompares = 0;

    logic [15:0] exp_addr[$], act_addr[$];
    logic [31:0] exp_data[$], act_data[$];
    int exp_done, exp_err, act_done, act_err, pulse_bad;
    logic prev_cpu_rst = 1'b0;

    // Observe DUT outputs on the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            act_addr.push_back(mem_addr);
            act_data.push_back(mem_wdata);
        end
        if (done === 1'b1) act_done++;
        if (err === 1'b1) act_err++;
        // CPU reset must drop exactly when a result pulse appears.
        if ((done === 1'b1 || err === 1'b1) && !(prev_cpu_rst === 1'b1 && cpu_rst === 1'b0))
            pulse_bad++;
        prev_cpu_rst = cpu_rst;
    end

    task automatic clear_obs();
        act_addr.delete(); act_data.delete();
        act_done = 0; act_err = 0; pulse_bad = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_dv   = 1'b1;
        @(posedge clk); #1;
        rx_dv   = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input byte_q_t f, input int maxgap);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (maxgap > 0) idle($urandom_range(0, maxgap));
        end
    endtask

    // Frame builder: header + words + checksum (corrupted when bad=1).
    task automatic build_frame(input int cnt, input logic [15:0] addr,
                               input logic [31:0] words[$], input bit bad,
                               output byte_q_t f);
        logic [7:0] s;
        f = {8'hA5, 8'(cnt), 8'(cnt >> 8), addr[7:0], addr[15:8]};
        foreach (words[w]) for (int k = 0; k < 4; k++) f.push_back(words[w][8*k +: 8]);
        s = 8'd0;
        for (int j = 1; j < f.size(); j++) s = s + f[j];
        f.push_back(bad ? s + 8'd1 : s);
    endtask

    // Reference model: skip bytes until SYNC, then decode the frame.
    task automatic model(input byte_q_t f);
        int i, cnt, b;
        logic [15:0] a;
        logic [7:0]  s;
        exp_addr.delete(); exp_data.delete();
        exp_done = 0; exp_err = 0;
        i = 0;
        while (f[i] != 8'hA5) i++;
        cnt = int'({f[i+2], f[i+1]});
        a   = {f[i+4], f[i+3]};
        s   = 8'd0;
        for (int j = i + 1; j < f.size() - 1; j++) s = s + f[j];
        for (int w = 0; w < cnt; w++) begin
            b = i + 5 + 4 * w;
            exp_addr.push_back(16'(int'(a) + w));
            exp_data.push_back({f[b+3], f[b+2], f[b+1], f[b]});
        end
        if (s == f[f.size()-1]) exp_done = 1; else exp_err = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_dv = 1'b0; rx_data = 8'h00;
        idle(3);
        vectors++;
        if ({mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got we=%b addr=%h data=%h cpu_rst=%b busy=%b done=%b err=%b, expected all 0",
                     mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic_frame();
        byte_q_t f = {8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h5E};
        clear_obs();
        send_byte(f[0]);
        vectors++;
        if (cpu_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL basic cpu_rst after sync: got %b expected 1", cpu_rst);
        end
        for (int i = 1; i < f.size(); i++) send_byte(f[i]);
        idle(4);
        vectors++;
        if (act_addr.size() != 2) begin
            miscompares++;
            $display("FAIL basic write count: got %0d expected 2", act_addr.size());
        end else begin
            vectors++;
            if (act_addr[0] !== 16'h0010 || act_data[0] !== 32'h12345678) begin
                miscompares++;
                $display("FAIL basic write0: got %h/%h expected 0010/12345678", act_addr[0], act_data[0]);
            end
            vectors++;
            if (act_addr[1] !== 16'h0011 || act_data[1] !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL basic write1: got %h/%h expected 0011/deadbeef", act_addr[1], act_data[1]);
            end
        end
        vectors++;
        if (act_done != 1 || act_err != 0 || pulse_bad != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic result: got done=%0d err=%0d pulse_bad=%0d busy=%b expected 1 0 0 0",
                     act_done, act_err, pulse_bad, busy);
        end
    endtask

    task automatic test_bad_csum();
        byte_q_t f = {8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h5F};
        clear_obs();
        send_frame(f, 2);
        idle(4);
        vectors++;
        if (act_addr.size() != 2 || act_data[0] !== 32'h12345678 || act_data[1] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL badcsum writes: got count %0d, expected 2 writes 12345678/deadbeef", act_addr.size());
        end
        vectors++;
        if (act_done != 0 || act_err != 1 || pulse_bad != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL badcsum result: got done=%0d err=%0d pulse_bad=%0d busy=%b expected 0 1 0 0",
                     act_done, act_err, pulse_bad, busy);
        end
    endtask

    task automatic test_leading_garbage();
        byte_q_t f = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_obs();
        send_byte(f[0]); send_byte(f[1]); send_byte(f[2]);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL garbage busy: got %b expected 0", busy);
        end
        for (int i = 3; i < f.size(); i++) send_byte(f[i]);
        idle(4);
        vectors++;
        if (act_addr.size() != 0 || act_done != 1 || act_err != 0) begin
            miscompares++;
            $display("FAIL garbage result: got writes=%0d done=%0d err=%0d expected 0 1 0",
                     act_addr.size(), act_done, act_err);
        end
    endtask

    task automatic test_addr_wrap();
        byte_q_t f;
        logic [31:0] w[$] = {32'h44332211, 32'h88776655};
        build_frame(2, 16'hFFFF, w, 1'b0, f);
        clear_obs();
        send_frame(f, 0);
        idle(4);
        vectors++;
        if (act_addr.size() != 2) begin
            miscompares++;
            $display("FAIL wrap write count: got %0d expected 2", act_addr.size());
        end else begin
            vectors++;
            if (act_addr[0] !== 16'hFFFF || act_addr[1] !== 16'h0000 || act_data[1] !== 32'h88776655) begin
                miscompares++;
                $display("FAIL wrap addrs: got %h %h data1 %h expected ffff 0000 88776655",
                         act_addr[0], act_addr[1], act_data[1]);
            end
        end
    endtask

    task automatic test_timeout();
        byte_q_t f = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        int n;
        clear_obs();
        send_frame(f, 0);
        n = 0;
        while (act_err == 0 && n < TMO + 50) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (act_err != 1 || n < TMO - 3 || n > TMO + 3) begin
            miscompares++;
            $display("FAIL timeout: got err=%0d after %0d cycles expected 1 after ~%0d", act_err, n, TMO);
        end
        idle(2);
        vectors++;
        if (act_addr.size() != 0 || busy !== 1'b0 || cpu_rst !== 1'b0 || act_done != 0 || pulse_bad != 0) begin
            miscompares++;
            $display("FAIL timeout state: got writes=%0d busy=%b cpu_rst=%b done=%0d expected 0 0 0 0",
                     act_addr.size(), busy, cpu_rst, act_done);
        end
    endtask

    task automatic test_async_reset();
        byte_q_t f = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        byte_q_t g;
        logic [31:0] w[$] = {32'hCAFEF00D};
        clear_obs();
        send_frame(f, 0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL async pre-reset busy: got %b expected 1", busy);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({mem_we, cpu_rst, busy, done, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL async reset outputs: got we=%b cpu_rst=%b busy=%b done=%b err=%b expected 0",
                     mem_we, cpu_rst, busy, done, err);
        end
        @(posedge clk); #1 rst = 1'b0;
        idle(1);
        build_frame(1, 16'h0020, w, 1'b0, g);
        send_frame(g, 1);
        idle(4);
        vectors++;
        if (act_addr.size() != 1 || act_addr[0] !== 16'h0020 || act_data[0] !== 32'hCAFEF00D || act_done != 1) begin
            miscompares++;
            $display("FAIL async reload: got writes=%0d done=%0d expected one write 0020/cafef00d and done",
                     act_addr.size(), act_done);
        end
    endtask

    task automatic test_random_frames();
        for (int t = 0; t < 20; t++) begin
            byte_q_t f, pre;
            logic [31:0] w[$];
            int cnt = $urandom_range(0, 4);
            for (int k = 0; k < cnt; k++) w.push_back($urandom);
            build_frame(cnt, 16'($urandom), w, ($urandom_range(0, 3) == 0), f);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                logic [7:0] g = 8'($urandom);
                if (g == 8'hA5) g = 8'h3C;
                pre.push_back(g);
            end
            f = {pre, f};
            model(f);
            clear_obs();
            send_frame(f, (t % 2 == 0) ? 0 : 3);
            idle(4);
            vectors++;
            if (act_addr.size() != exp_addr.size()) begin
                miscompares++;
                $display("FAIL rand%0d write count: got %0d expected %0d", t, act_addr.size(), exp_addr.size());
            end else begin
                foreach (exp_addr[k]) begin
                    vectors++;
                    if (act_addr[k] !== exp_addr[k] || act_data[k] !== exp_data[k]) begin
                        miscompares++;
                        $display("FAIL rand%0d write%0d: got %h/%h expected %h/%h",
                                 t, k, act_addr[k], act_data[k], exp_addr[k], exp_data[k]);
                    end
                end
            end
            vectors++;
            if (act_done != exp_done || act_err != exp_err || pulse_bad != 0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d result: got done=%0d err=%0d pulse_bad=%0d busy=%b expected done=%0d err=%0d",
                         t, act_done, act_err, pulse_bad, busy, exp_done, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bad_csum();
        test_leading_garbage();
        test_addr_wrap();
        test_timeout();
        test_async_reset();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
